perf_sampler: RTL and testbench

Periodic snapshot engine directly downstream of the performance counter CSR block. Every sample period it walks the counter bank's SRAM-like read port (address/we/wdata/rdata) and reads every aux counter. It then emits one packet per snapshot, a header word followed by one word per counter, on a valid/ready trace stream toward the tile's debug/trace sink. This replaces simulation-only file logging with synthesizable, back-pressured export.

---
 rtl/perf_sampler_pkg.sv | 24 ++
 rtl/perf_sampler_fifo.sv | 68 ++++++
 rtl/perf_sampler.sv | 167 ++++++++++++++++
 tb/tb_perf_sampler.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_sampler_pkg.sv
// Shared types for the performance-counter snapshot engine.
// Holds the header word layout, FSM state encoding and a saturating increment helper.
package perf_sampler_pkg;

  localparam int unsigned PERF_SAMPLE_HDR_W = 64;

  typedef struct packed {
    logic [15:0] core_id;
    logic [7:0]  drops;
    logic [7:0]  seq;
    logic [31:0] timestamp;
  } perf_sample_hdr_t;

  typedef enum logic [1:0] {
    StIdle,
    StHeader,
    StRead
  } perf_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/perf_sampler_fifo.sv
// Show-ahead synchronous FIFO for the trace stream (registered write, head visible from storage).
// Reports free entries so the sampler can admit a whole packet up front.
module perf_sampler_fifo #(
  parameter int unsigned Width = 65,
  parameter int unsigned Depth = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [Width-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [Width-1:0]             rdata_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   free_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CntW-1:0]  count_d, count_q;
  logic             full, push_ok, pop_ok;

  always_comb begin
    empty_o = (count_q == '0);
    full    = (count_q == CntW'(Depth));
    push_ok = push_i && !full;
    pop_ok  = pop_i && !empty_o;
    free_o  = CntW'(Depth) - count_q;
    rdata_o = mem_q[rd_ptr_q];

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CntW'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Storage is not reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/perf_sampler.sv
// Periodic snapshot engine: walks the counter bank every sample period and emits
// a header word plus one word per counter on a back-pressured trace stream.
module perf_sampler
  import perf_sampler_pkg::*;
#(
  parameter int unsigned CORE_ADDR     = 1,
  parameter int unsigned NUM_CTR       = 14,
  parameter int unsigned BASE_ADDR     = 3,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter bit          CLEAR_ON_READ = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        debug_mode_i,
  input  logic [31:0] period_i,
  output logic [4:0]  ctr_addr_o,
  output logic        ctr_we_o,
  output logic [63:0] ctr_wdata_o,
  input  logic [63:0] ctr_rdata_i,
  output logic        trace_valid_o,
  input  logic        trace_ready_i,
  output logic [63:0] trace_data_o,
  output logic        trace_last_o
);

  localparam int unsigned PktLen = NUM_CTR + 1;
  localparam int unsigned IdxW   = (NUM_CTR > 1) ? $clog2(NUM_CTR) : 1;
  localparam int unsigned FreeW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FifoW  = PERF_SAMPLE_HDR_W + 1;

  perf_state_e      state_d, state_q, cur_state;
  logic [IdxW-1:0]  idx_d, idx_q;
  logic [31:0]      timer_d, timer_q, timer_cur, eff_period, reload;
  logic             armed_d, armed_q;
  logic [7:0]       seq_d, seq_q, drop_cnt_d, drop_cnt_q;
  logic [31:0]      ts_d, ts_q;
  logic             tick, admit, drop;

  logic             push, push_last;
  logic [63:0]      push_data;
  logic [4:0]       addr;
  logic             we;
  perf_sample_hdr_t hdr;

  logic [FifoW-1:0] fifo_head;
  logic             fifo_empty;
  logic [FreeW-1:0] fifo_free;

  // Until the first enabled cycle after reset the timer reads as its reload value,
  // which keeps the reset value a constant while honouring the current period.
  always_comb begin
    eff_period = (period_i < 32'(PktLen)) ? 32'(PktLen) : period_i;
    reload     = eff_period - 32'd1;
    timer_cur  = armed_q ? timer_q : reload;
    tick       = 1'b0;
    timer_d    = reload;
    armed_d    = armed_q;
    if (enable_i) begin
      armed_d = 1'b1;
      if (timer_cur == '0) begin
        tick    = 1'b1;
        timer_d = reload;
      end else begin
        timer_d = timer_cur - 32'd1;
      end
    end
    ts_d = ts_q + 32'd1;
  end

  // The header occupies the admitted tick cycle itself, so a packet spans exactly
  // NUM_CTR+1 cycles and back-to-back packets fit the minimum period.
  always_comb begin
    admit     = tick && !debug_mode_i && (state_q == StIdle) &&
                (fifo_free >= FreeW'(PktLen));
    drop      = tick && !debug_mode_i && !admit;
    cur_state = admit ? StHeader : state_q;

    state_d    = state_q;
    idx_d      = idx_q;
    seq_d      = seq_q;
    drop_cnt_d = drop_cnt_q;
    push       = 1'b0;
    push_last  = 1'b0;
    push_data  = '0;
    addr       = 5'(BASE_ADDR);
    we         = 1'b0;

    hdr.core_id   = 16'(CORE_ADDR);
    hdr.drops     = drop_cnt_q;
    hdr.seq       = seq_q;
    hdr.timestamp = ts_q;

    unique case (cur_state)
      StHeader: begin
        push       = 1'b1;
        push_data  = hdr;
        seq_d      = seq_q + 8'd1;
        drop_cnt_d = '0;
        state_d    = StRead;
        idx_d      = '0;
      end
      StRead: begin
        addr      = 5'(BASE_ADDR) + 5'(idx_q);
        push      = 1'b1;
        push_data = ctr_rdata_i;
        we        = CLEAR_ON_READ;
        if (idx_q == IdxW'(NUM_CTR - 1)) begin
          push_last = 1'b1;
          state_d   = StIdle;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      default: ;
    endcase

    if (drop) begin
      drop_cnt_d = (cur_state == StHeader) ? 8'd1 : sat_inc8(drop_cnt_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      timer_q    <= '0;
      armed_q    <= 1'b0;
      seq_q      <= '0;
      drop_cnt_q <= '0;
      ts_q       <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      armed_q    <= armed_d;
      seq_q      <= seq_d;
      drop_cnt_q <= drop_cnt_d;
      ts_q       <= ts_d;
    end
  end

  perf_sampler_fifo #(
    .Width (FifoW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i ({push_last, push_data}),
    .pop_i   (trace_ready_i),
    .rdata_o (fifo_head),
    .empty_o (fifo_empty),
    .free_o  (fifo_free)
  );

  // Outputs are forced to zero while reset is held, including the idle bank address.
  always_comb begin
    ctr_addr_o    = rst_i ? 5'd0 : addr;
    ctr_we_o      = rst_i ? 1'b0 : we;
    ctr_wdata_o   = '0;
    trace_valid_o = !fifo_empty;
    trace_data_o  = fifo_empty ? '0 : fifo_head[63:0];
    trace_last_o  = !fifo_empty && fifo_head[64];
  end

endmodule

// File: tb/tb_perf_sampler.sv
// Scoreboard bench for perf_sampler: directed packets are queued as expected words
// and per-instance monitors pop and compare whenever a trace word is accepted.
module tb_perf_sampler;

  typedef struct {
    logic [63:0] data;
    logic [63:0] mask;
    logic        last;
    int          delta;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: CLEAR_ON_READ=0 with a constant counter bank.
  logic        rst = 1'b1, enable = 1'b0, debug = 1'b0, ready0 = 1'b0;
  logic [31:0] period = 32'd100;
  logic [4:0]  addr0;
  logic        we0, valid0, last0;
  logic [63:0] wdata0, rdata0, data0;

  // Instance 1: CLEAR_ON_READ=1 with a writable counter bank.
  logic        rst1 = 1'b1, enable1 = 1'b0, debug1 = 1'b0, ready1 = 1'b1;
  logic [31:0] period1 = 32'd20;
  logic [4:0]  addr1;
  logic        we1, valid1, last1;
  logic [63:0] wdata1, rdata1, data1;
  logic [63:0] bank1 [32];
  logic        bank_load = 1'b0, bump = 1'b0;

  exp_t        q0[$], q1[$];
  int          total = 0, bad = 0;
  int          hdrs[2] = '{0, 0};
  logic [31:0] last_ts[2];
  int          we0_cnt = 0, we1_cnt = 0;
  logic [4:0]  we1_first = 5'd0;
  logic        we1_seen = 1'b0;

  perf_sampler #(.CLEAR_ON_READ(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .debug_mode_i(debug), .period_i(period),
    .ctr_addr_o(addr0), .ctr_we_o(we0), .ctr_wdata_o(wdata0), .ctr_rdata_i(rdata0),
    .trace_valid_o(valid0), .trace_ready_i(ready0), .trace_data_o(data0), .trace_last_o(last0)
  );

  perf_sampler #(.CLEAR_ON_READ(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst1), .enable_i(enable1), .debug_mode_i(debug1), .period_i(period1),
    .ctr_addr_o(addr1), .ctr_we_o(we1), .ctr_wdata_o(wdata1), .ctr_rdata_i(rdata1),
    .trace_valid_o(valid1), .trace_ready_i(ready1), .trace_data_o(data1), .trace_last_o(last1)
  );

  assign rdata0 = (addr0 >= 5'd3 && addr0 < 5'd17) ? 64'h1000 + 64'(addr0 - 5'd3) : 64'h0;
  assign rdata1 = bank1[addr1];

  always @(posedge clk) begin
    if (bank_load) begin
      for (int i = 0; i < 32; i++) begin
        bank1[i] <= (i >= 3 && i < 17) ? 64'h1000 + 64'(i - 3) : 64'h0;
      end
      bank1[3] <= 64'd7;
    end else begin
      if (we1) bank1[addr1] <= 64'h0;
      if (bump && !(we1 && addr1 == 5'd3)) bank1[3] <= bank1[3] + 64'd1;
    end
  end

  task automatic push_pkt(input int which, input int seq, input int drops, input int delta,
                          input logic [63:0] w1, input bit zero_rest);
    exp_t e;
    e.data  = {16'h0001, 8'(drops), 8'(seq), 32'h0};
    e.mask  = {32'hFFFF_FFFF, 32'h0};
    e.last  = 1'b0;
    e.delta = delta;
    if (which == 0) q0.push_back(e); else q1.push_back(e);
    for (int i = 0; i < 14; i++) begin
      e.data  = (i == 0) ? w1 : (zero_rest ? 64'h0 : 64'h1000 + 64'(i));
      e.mask  = '1;
      e.last  = (i == 13);
      e.delta = 0;
      if (which == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic mon_pop(input int which, input logic [63:0] d, input logic l);
    exp_t e;
    total++;
    if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
      bad++;
      $display("FAIL unexpected_word dut%0d: got %h last=%0b, none required", which, d, l);
      return;
    end
    e = (which == 0) ? q0.pop_front() : q1.pop_front();
    if ((d & e.mask) !== (e.data & e.mask) || l !== e.last) begin
      bad++;
      $display("FAIL word dut%0d: got %h last=%0b, required %h last=%0b (mask %h)",
               which, d, l, e.data, e.last, e.mask);
    end
    if (e.mask != '1) begin
      hdrs[which]++;
      if (e.delta != 0) begin
        total++;
        if (d[31:0] - last_ts[which] != 32'(e.delta)) begin
          bad++;
          $display("FAIL ts_delta dut%0d: got %0d required %0d",
                   which, d[31:0] - last_ts[which], e.delta);
        end
      end
      last_ts[which] = d[31:0];
    end
  endtask

  // Monitor for instance 0: pops on accept and checks data holds while stalled.
  initial begin
    logic        hold;
    logic [64:0] held;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (we0) we0_cnt++;
        if (hold) begin
          total++;
          if (!valid0 || {last0, data0} !== held) begin
            bad++;
            $display("FAIL stall_hold: got valid=%0b %h, required valid=1 %h",
                     valid0, {last0, data0}, held);
          end
        end
        if (valid0 && ready0) mon_pop(0, data0, last0);
        hold = valid0 && !ready0;
        held = {last0, data0};
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst1) begin
        if (we1) begin
          we1_cnt++;
          if (!we1_seen) begin
            we1_seen  = 1'b1;
            we1_first = addr1;
          end
        end
        if (valid1 && ready1) mon_pop(1, data1, last1);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic wait_hdrs(input int which, input int n, input int budget, input string nm);
    int k = 0;
    while (hdrs[which] < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    #2;
    chk(nm, 64'(hdrs[which]), 64'(n));
  endtask

  task automatic wait_empty(input int which, input int budget, input string nm);
    int k = 0;
    while (((which == 0) ? q0.size() : q1.size()) != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    #2;
    chk(nm, 64'((which == 0) ? q0.size() : q1.size()), 64'd0);
  endtask

  task automatic restart0(input logic [31:0] p, input logic r, input logic dbg);
    rst    = 1'b1;
    enable = 1'b0;
    period = p;
    ready0 = r;
    debug  = dbg;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    rst    = 1'b0;
  endtask

  initial begin
    int base;
    int k;
    bank_load = 1'b1;
    repeat (2) @(negedge clk);
    bank_load = 1'b0;
    #1;
    chk("reset_valid", 64'(valid0), 64'd0);
    chk("reset_addr", 64'(addr0), 64'd0);

    // 1: period 100, two packets, seq 0 then 1, spaced 100 cycles.
    restart0(32'd100, 1'b1, 1'b0);
    base = hdrs[0];
    push_pkt(0, 0, 0, 0, 64'h1000, 1'b0);
    push_pkt(0, 1, 0, 100, 64'h1000, 1'b0);
    #1;
    chk("idle_addr", 64'(addr0), 64'd3);
    wait_hdrs(0, base + 2, 300, "t1_headers");
    enable = 1'b0;
    wait_empty(0, 50, "t1_drain");

    // 2: period 5 clamps to 15; three packets back to back with no drops.
    restart0(32'd5, 1'b1, 1'b0);
    base = hdrs[0];
    push_pkt(0, 0, 0, 0, 64'h1000, 1'b0);
    push_pkt(0, 1, 0, 15, 64'h1000, 1'b0);
    push_pkt(0, 2, 0, 15, 64'h1000, 1'b0);
    wait_hdrs(0, base + 3, 100, "t2_headers");
    enable = 1'b0;
    wait_empty(0, 50, "t2_drain");

    // 3: sink stalled 400 cycles at period 20; 19 ticks dropped while full.
    restart0(32'd20, 1'b0, 1'b0);
    base = hdrs[0];
    push_pkt(0, 0, 0, 0, 64'h1000, 1'b0);
    push_pkt(0, 1, 19, 400, 64'h1000, 1'b0);
    repeat (400) @(negedge clk);
    ready0 = 1'b1;
    wait_hdrs(0, base + 2, 100, "t3_headers");
    enable = 1'b0;
    wait_empty(0, 50, "t3_drain");

    // 5: reset at READ idx 6 with the sink stalled; packet aborted and FIFO flushed.
    restart0(32'd20, 1'b0, 1'b0);
    k = 0;
    while (addr0 != 5'd9 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t5_reach_idx6", 64'(addr0), 64'd9);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(valid0), 64'd0);
    chk("t5_rst_addr", 64'(addr0), 64'd0);
    chk("t5_rst_we", 64'(we0), 64'd0);
    chk("t5_rst_data", data0, 64'd0);
    chk("t5_rst_last", 64'(last0), 64'd0);
    @(negedge clk);
    rst    = 1'b0;
    ready0 = 1'b1;
    base   = hdrs[0];
    push_pkt(0, 0, 0, 0, 64'h1000, 1'b0);
    #1;
    chk("t5_post_empty", 64'(valid0), 64'd0);
    wait_hdrs(0, base + 1, 60, "t5_headers");
    enable = 1'b0;
    wait_empty(0, 50, "t5_drain");

    // 6: debug mode across three ticks, then sampling resumes without drops.
    restart0(32'd20, 1'b1, 1'b1);
    base = hdrs[0];
    repeat (70) @(negedge clk);
    chk("t6_debug_no_pkt", 64'(hdrs[0] - base), 64'd0);
    chk("t6_debug_valid", 64'(valid0), 64'd0);
    debug = 1'b0;
    push_pkt(0, 0, 0, 0, 64'h1000, 1'b0);
    wait_hdrs(0, base + 1, 40, "t6_headers");
    enable = 1'b0;
    wait_empty(0, 50, "t6_drain");

    // 4: clear-on-read; second snapshot of counter 0 holds only the 5 later increments.
    push_pkt(1, 0, 0, 0, 64'd7, 1'b0);
    push_pkt(1, 1, 0, 20, 64'd5, 1'b1);
    enable1 = 1'b1;
    rst1    = 1'b0;
    wait_hdrs(1, 1, 60, "t4_first_header");
    repeat (3) @(negedge clk);
    bump = 1'b1;
    repeat (5) @(negedge clk);
    bump = 1'b0;
    wait_hdrs(1, 2, 60, "t4_second_header");
    enable1 = 1'b0;
    wait_empty(1, 50, "t4_drain");
    chk("t4_we_pulses", 64'(we1_cnt), 64'd28);
    chk("t4_first_we_addr", 64'(we1_first), 64'd3);
    chk("no_we_without_clear", 64'(we0_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
